register_usr: RTL and testbench
===============================

REGISTER_USR -- requirements
Module: register_usr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into OUT on reset.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port MODE  input  2  operation select: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
REQ-006 SHALL have port IN  input  WIDTH  parallel load data.
REQ-007 SHALL have port SIN_MSB  input  1  serial bit shifted into OUT[WIDTH-1] on SHR.
REQ-008 SHALL have port SIN_LSB  input  1  serial bit shifted into OUT[0] on SHL.
REQ-009 SHALL have port START  input  1  serializer request; sampled only in IDLE.
REQ-010 SHALL have port OUT  output  WIDTH  register contents.
REQ-011 SHALL have port SOUT  output  1  serial output; always equal to OUT[0].
REQ-012 SHALL have port BUSY  output  1  high while the serializer is in SHIFT.
REQ-013 SHALL have port DONE  output  1  single-cycle pulse at serializer completion.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SHIFT, plus a down-counter of ceil(log2(WIDTH+1)) bits.
REQ-015 SHALL, in IDLE with START=0, apply MODE at each edge: HOLD keeps OUT; SHR gives {SIN_MSB, OUT[WIDTH-1:1]}; SHL gives {OUT[WIDTH-2:0], SIN_LSB}; LOAD gives IN.
REQ-016 SHALL, in IDLE with START=1, load IN into OUT, set the counter to WIDTH, and enter SHIFT; START takes priority over MODE in that cycle.
REQ-017 SHALL, in SHIFT, perform an SHR using SIN_MSB at each edge and decrement the counter, so SOUT presents IN[0]..IN[WIDTH-1] in cycles 1..WIDTH after the START cycle.
REQ-018 SHALL, at the edge where the counter reaches 0, return to IDLE and assert DONE for exactly the following cycle.
REQ-019 SHALL hold BUSY high for exactly WIDTH cycles, from cycle 1 through cycle WIDTH.
REQ-020 SHALL ignore MODE and START while in SHIFT, with no queuing.
REQ-021 SHALL accept a new START in the DONE cycle, so back-to-back words are separated by exactly one idle cycle.
REQ-022 SHALL drive OUT, SOUT, BUSY and DONE directly from registers or from OUT[0], with no combinational path from inputs.

Reset
REQ-023 SHALL, while RST_N=0, immediately force OUT=RESET_VAL, state IDLE, counter 0, BUSY=0, DONE=0, independent of CLK.
REQ-024 SHALL abort any serialization on reset mid-operation; DONE SHALL NOT pulse for the aborted word.
REQ-025 SHALL honour MODE and START at the first rising edge after RST_N deasserts.

Configuration
REQ-026 SHALL, when macro REGISTER_USR_ROTATE_EN is defined, add port ROT  input  1; with ROT=1, SHR and SHL (MODE only) rotate (OUT[0] into MSB, or OUT[WIDTH-1] into LSB), and SIN_MSB/SIN_LSB are ignored.
REQ-027 SHALL, when REGISTER_USR_ROTATE_EN is undefined, have no ROT port, and shifts always use SIN_MSB/SIN_LSB; the serializer SHALL behave identically in both builds.

Verification (WIDTH=8, RESET_VAL=0)
REQ-028 SHALL check: MODE=11, IN=0xA5, one edge -> OUT=0xA5; MODE=00 for 3 edges -> OUT stays 0xA5.
REQ-029 SHALL check: OUT=0x81, MODE=01, SIN_MSB=0 -> OUT=0x40; separately, OUT=0x81, MODE=10, SIN_LSB=1 -> OUT=0x03.
REQ-030 SHALL check: START=1, IN=0xB4, SIN_MSB=0 -> SOUT over cycles 1..8 = 0,0,1,0,1,1,0,1; BUSY high for 8 cycles; DONE high only in cycle 9; OUT=0x00 in cycle 9.
REQ-031 SHALL check: RST_N pulsed low in cycle 4 of a serialization -> OUT=0x00 and BUSY=0 without waiting for a clock edge, no DONE pulse, and the next START is accepted normally.
REQ-032 SHALL check: START with MODE=11 in IDLE -> serializer runs; START=1 and MODE=11 during BUSY -> no effect; START in the DONE cycle -> a new word starts.
REQ-033 SHALL check: with REGISTER_USR_ROTATE_EN, OUT=0x81, MODE=01, ROT=1 -> OUT=0xC0; without the macro, the same stimulus minus ROT, with SIN_MSB=0 -> OUT=0x40.

Source files
------------

// File: rtl/register_usr.sv
// Universal shift register with a built-in LSB-first serializer (IDLE/SHIFT FSM).
// Optional rotate support on MODE-driven shifts is enabled by defining REGISTER_USR_ROTATE_EN.
module register_usr #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] IN,
  input  logic             SIN_MSB,
  input  logic             SIN_LSB,
  input  logic             START,
  output logic [WIDTH-1:0] OUT,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
`ifdef REGISTER_USR_ROTATE_EN
  ,
  input  logic             ROT
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHR  = 2'b01,
    M_SHL  = 2'b10,
    M_LOAD = 2'b11
  } mode_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rot_en;
  logic             shr_fill;
  logic             shl_fill;

`ifdef REGISTER_USR_ROTATE_EN
  assign rot_en = ROT;
`else
  assign rot_en = 1'b0;
`endif

  // Rotation only affects MODE-driven shifts; the serializer always shifts in SIN_MSB.
  assign shr_fill = rot_en ? out_q[0]       : SIN_MSB;
  assign shl_fill = rot_en ? out_q[WIDTH-1] : SIN_LSB;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          out_d   = IN;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
          busy_d  = 1'b1;
        end else begin
          case (mode_e'(MODE))
            M_SHR:   out_d = {shr_fill, out_q[WIDTH-1:1]};
            M_SHL:   out_d = {out_q[WIDTH-2:0], shl_fill};
            M_LOAD:  out_d = IN;
            default: out_d = out_q;
          endcase
        end
      end
      SHIFT: begin
        out_d = {SIN_MSB, out_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        // The last shift lands on the edge where the count hits zero.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      out_q   <= RESET_VAL;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign OUT  = out_q;
  assign SOUT = out_q[0];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_register_usr.sv
// Directed self-checking bench for register_usr (WIDTH=8, RESET_VAL=0, default build).
module tb_register_usr;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] din;
  logic       sin_msb;
  logic       sin_lsb;
  logic       start;
  logic [7:0] dout;
  logic       sout;
  logic       busy;
  logic       done;

  int unsigned checks;
  int unsigned errors;

  register_usr #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .MODE   (mode),
    .IN     (din),
    .SIN_MSB(sin_msb),
    .SIN_LSB(sin_lsb),
    .START  (start),
    .OUT    (dout),
    .SOUT   (sout),
    .BUSY   (busy),
    .DONE   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue START for word w and follow it through cycles 1..9.
  // With junk set, START/MODE=LOAD/IN=FF are driven throughout BUSY.
  task automatic send(input logic [7:0] w, input bit junk);
    din   = w;
    start = 1'b1;
    step();
    if (junk) begin
      start = 1'b1;
      mode  = 2'b11;
      din   = 8'hFF;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      check_eq("ser_sout", 64'(sout), 64'(w[i]));
      check_eq("ser_busy", 64'(busy), 64'd1);
      check_eq("ser_done", 64'(done), 64'd0);
      step();
    end
    check_eq("ser_done_c9", 64'(done), 64'd1);
    check_eq("ser_busy_c9", 64'(busy), 64'd0);
    check_eq("ser_out_c9", 64'(dout), 64'h00);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    mode    = 2'b11;
    din     = 8'hA5;
    sin_msb = 1'b0;
    sin_lsb = 1'b0;
    start   = 1'b0;

    #3;
    check_eq("rst_out", 64'(dout), 64'h00);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sout", 64'(sout), 64'd0);

    // First edge after reset release must honour MODE=LOAD.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("load_a5", 64'(dout), 64'hA5);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_a5", 64'(dout), 64'hA5);
    end

    mode = 2'b11; din = 8'h81; step();
    mode = 2'b01; sin_msb = 1'b0; step();
    check_eq("shr_81_0", 64'(dout), 64'h40);
    check_eq("shr_sout", 64'(sout), 64'd0);

    mode = 2'b11; din = 8'h81; step();
    mode = 2'b10; sin_lsb = 1'b1; step();
    check_eq("shl_81_1", 64'(dout), 64'h03);
    check_eq("shl_sout", 64'(sout), 64'd1);

    mode = 2'b11; din = 8'h81; step();
    mode = 2'b01; sin_msb = 1'b1; step();
    check_eq("shr_81_1", 64'(dout), 64'hC0);
    sin_msb = 1'b0;

    // Basic serialization.
    mode = 2'b00;
    send(8'hB4, 1'b0);
    step();
    check_eq("done_pulse_end", 64'(done), 64'd0);
    check_eq("idle_out", 64'(dout), 64'h00);

    // START beats MODE=LOAD, junk during BUSY ignored, START in DONE cycle accepted.
    mode = 2'b11;
    send(8'h3C, 1'b1);
    mode = 2'b00;
    send(8'h5A, 1'b0);
    step();
    check_eq("b2b_done_end", 64'(done), 64'd0);

    // Reset in cycle 4 of a serialization.
    din = 8'hB4; start = 1'b1; step();
    start = 1'b0;
    step(); step(); step();
    check_eq("mid_busy", 64'(busy), 64'd1);
    check_eq("mid_out", 64'(dout), 64'h16);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_out", 64'(dout), 64'h00);
    check_eq("async_busy", 64'(busy), 64'd0);
    check_eq("async_done", 64'(done), 64'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("abort_nodone", 64'(done), 64'd0);
      check_eq("abort_nobusy", 64'(busy), 64'd0);
    end
    send(8'h96, 1'b0);
    step();
    check_eq("final_done_end", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
